axi4_video_to_hv_timing_gen: RTL and testbench
==============================================

Name: axi4_video_to_hv_timing_gen

Overview:
Converts an AXI4-Stream video stream into a timed pixel bus (RGB, data-enable, h/v sync) with its own full video timing generator: porches, sync widths and sync polarity are parametrised. Pixels are pulled from the stream with real backpressure, only during the active region. The block locks to start-of-frame (tuser) and detects stream underflow and framing errors. After an error it blanks and resynchronises at the next frame start. It sits between the video pipeline and the HDMI/TMDS encoder.

Parameters:
PX_WIDTH, 10, bits per colour component in tdata; tdata width is 3*PX_WIDTH
OUT_WIDTH, 8, bits per output colour; must be <= PX_WIDTH; the MSBs of each component are taken
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch in clocks
H_SYNC, 44, horizontal sync width in clocks
H_BP, 148, horizontal back porch in clocks
V_ACTIVE, 1080, active lines
V_FP, 4, vertical front porch in lines
V_SYNC, 5, vertical sync width in lines
V_BP, 36, vertical back porch in lines
H_POL, 1, h_sync active level
V_POL, 1, v_sync active level

Ports:
clk_i  in  1  pixel clock
rst_n_i  in  1  asynchronous active-low reset
axi4_video_i  slave  axi4_stream_if  tdata[3*PX_WIDTH-1:0] holds red (top slice), blue (middle), green (bottom); tuser marks SOF; tlast marks EOL
red_o  out  OUT_WIDTH  red
green_o  out  OUT_WIDTH  green
blue_o  out  OUT_WIDTH  blue
de_o  out  1  active video
h_sync_o  out  1  horizontal sync, H_POL level when asserted
v_sync_o  out  1  vertical sync, V_POL level when asserted
locked_o  out  1  stream is aligned to the timing
underflow_o  out  1  one-cycle pulse on underflow
frame_err_o  out  1  one-cycle pulse on tuser/tlast misplacement

Behaviour:
- Reset values: all colours 0, de_o 0, h_sync_o !H_POL, v_sync_o !V_POL, locked_o 0, pulse outputs 0. Counters h=0, v=0. State is WAIT_SOF.
- Timing counters run freely from reset.
  - h counts 0..H_TOTAL-1 in the order active, FP, SYNC, BP. H_TOTAL is the sum of the four H parameters.
  - v increments when h wraps, and counts 0..V_TOTAL-1 in the same order.
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
- Output latency: every output is registered. It is valid 1 clock after the counter value it belongs to.
  - de_o is high exactly when the region is active, in every state.
  - Sync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and likewise for v.
- State WAIT_SOF:
  - tready = !(tvalid && tuser). Non-SOF beats are discarded and the SOF beat is held.
  - Transition to LOCKED when an SOF beat is held and the counters are at h=H_TOTAL-1, v=V_TOTAL-1, so the first active pixel is consumed at h=0, v=0.
  - Colours are 0 while in this state.
- State LOCKED:
  - tready = 1 in the active region only. Consumed tdata is output 1 cycle later with de_o. locked_o = 1.
  - Underflow: tvalid=0 in the active region. Output black for that pixel, pulse underflow_o, go to RESYNC.
  - Frame error, any of:
    - tuser=1 on a beat consumed at (h,v) other than (0,0);
    - tlast=1 at h != H_ACTIVE-1;
    - tlast=0 at h = H_ACTIVE-1.
  - On a frame error, still output that pixel, pulse frame_err_o, go to RESYNC.
- State RESYNC: locked_o = 0. tready behaves as in WAIT_SOF, and colours are 0. Transition to WAIT_SOF in the next cycle.
- Simultaneous events: underflow and frame error are mutually exclusive because no beat is consumed on underflow. An SOF beat arriving in WAIT_SOF during the alignment cycle locks immediately.
- Timing counters are never reset by stream events. Only rst_n_i resets them.

Optional Feature:
AXI4_HV_TEST_PATTERN_EN:
- Defined: while not LOCKED, active pixels show 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black; components full-scale or 0). Bar index is h*8/H_ACTIVE.
- Undefined: active pixels are black when not LOCKED.
- Stream handling and sync are identical in both builds.

Test Plan:
Use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (H_TOTAL=14, V_TOTAL=7) and polarity 1 for every scenario.
- Timing with no stream: de_o high 8 of every 14 clocks on lines 0-3. h_sync_o high at h=10,11. v_sync_o high on line 5. Colours 0.
- Lock and pass-through: a well-formed frame with red=0x3FF, green=0x001, blue=0x200 gives locked_o=1 from the first pixel of the next frame. Outputs are red=0xFF, green=0x00, blue=0x80. tready is high only during active pixels.
- Underflow: drop tvalid at pixel (3,1). Response: underflow_o pulse, pixel black, locked_o=0, stream drained. Lock returns at the next SOF aligned to (0,0).
- Early tlast at pixel (5,2): frame_err_o pulses, then resync, then lock on the following frame.
- Stray tuser at (2,0): frame_err_o pulses. Pixel (2,0) is still output. The SOF beat is held and locks at the next frame boundary.
- Reset mid-frame (rst_n_i low for 2 clocks at h=4, v=2): all outputs return to reset values, counters restart at 0, state WAIT_SOF.
- With AXI4_HV_TEST_PATTERN_EN defined and unlocked: pixel at h=1 is white (0xFF,0xFF,0xFF) and h=7 is black.

Source files
------------

// File: rtl/axi4_video_to_hv_timing_gen_if.sv
// AXI4-Stream video link: tdata carries {red, blue, green}, tuser marks
// start-of-frame and tlast marks end-of-line.
interface axi4_stream_if #(
  parameter int DATA_W = 30
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axi4_video_to_hv_timing_gen.sv
// AXI4-Stream video to timed RGB/DE/HSYNC/VSYNC bus with its own timing generator.
// Optional build macro AXI4_HV_TEST_PATTERN_EN shows colour bars while unlocked.
module axi4_video_to_hv_timing_gen #(
  parameter int PX_WIDTH  = 10,
  parameter int OUT_WIDTH = 8,
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  axi4_stream_if.slave         axi4_video_i,
  output logic [OUT_WIDTH-1:0] red_o,
  output logic [OUT_WIDTH-1:0] green_o,
  output logic [OUT_WIDTH-1:0] blue_o,
  output logic                 de_o,
  output logic                 h_sync_o,
  output logic                 v_sync_o,
  output logic                 locked_o,
  output logic                 underflow_o,
  output logic                 frame_err_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic HS_ON = 1'(H_POL);
  localparam logic VS_ON = 1'(V_POL);

  typedef enum logic [1:0] {WAIT_SOF, LOCKED, RESYNC} state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic           active, sof_beat, at_align, at_origin, at_eol;
  logic           tready, take, uf_d, fe_d;
  logic [OUT_WIDTH-1:0] pix_r, pix_g, pix_b;
  logic           stream_unused;

  assign stream_unused = ^axi4_video_i.tdata;

  // Free-running raster counters; stream events never touch them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign sof_beat  = axi4_video_i.tvalid && axi4_video_i.tuser;
  assign at_align  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign at_eol    = (h_cnt == H_EOL);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= WAIT_SOF;
    else          state_q <= state_d;
  end

  // Unlocked states drain non-SOF beats and hold the SOF beat until the
  // raster reaches the last clock of the frame.
  always_comb begin
    state_d = state_q;
    tready  = 1'b1;
    take    = 1'b0;
    uf_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        tready = !sof_beat;
        if (sof_beat && at_align) state_d = LOCKED;
      end
      LOCKED: begin
        tready = active;
        if (active) begin
          if (!axi4_video_i.tvalid) begin
            uf_d    = 1'b1;
            state_d = RESYNC;
          end else begin
            take = 1'b1;
            if ((axi4_video_i.tuser && !at_origin) || (axi4_video_i.tlast != at_eol)) begin
              fe_d    = 1'b1;
              state_d = RESYNC;
            end
          end
        end
      end
      RESYNC: begin
        tready  = !sof_beat;
        state_d = WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  assign axi4_video_i.tready = tready;

`ifdef AXI4_HV_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb bar = 3'((int'(h_cnt) * 8) / H_ACTIVE);
`endif

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (take) begin
      pix_r = axi4_video_i.tdata[3*PX_WIDTH-1 -: OUT_WIDTH];
      pix_b = axi4_video_i.tdata[2*PX_WIDTH-1 -: OUT_WIDTH];
      pix_g = axi4_video_i.tdata[PX_WIDTH-1 -: OUT_WIDTH];
    end
`ifdef AXI4_HV_TEST_PATTERN_EN
    else if (state_q != LOCKED && active) begin
      pix_r = {OUT_WIDTH{~bar[1]}};
      pix_g = {OUT_WIDTH{~bar[2]}};
      pix_b = {OUT_WIDTH{~bar[0]}};
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      red_o       <= '0;
      green_o     <= '0;
      blue_o      <= '0;
      de_o        <= 1'b0;
      h_sync_o    <= !HS_ON;
      v_sync_o    <= !VS_ON;
      locked_o    <= 1'b0;
      underflow_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      red_o       <= pix_r;
      green_o     <= pix_g;
      blue_o      <= pix_b;
      de_o        <= active;
      h_sync_o    <= (h_cnt >= H_SYNC_S && h_cnt <= H_SYNC_E) ? HS_ON : !HS_ON;
      v_sync_o    <= (v_cnt >= V_SYNC_S && v_cnt <= V_SYNC_E) ? VS_ON : !VS_ON;
      locked_o    <= (state_q == LOCKED);
      underflow_o <= uf_d;
      frame_err_o <= fe_d;
    end
  end

endmodule

// File: tb/tb_axi4_video_to_hv_timing_gen.sv
// Scoreboard bench: 14x7 raster, stream fed frame by frame with injected faults.
module tb_axi4_video_to_hv_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] red, green, blue;
  logic de, hs, vs, locked, uf, fe;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_W(30)) vid ();

  axi4_video_to_hv_timing_gen #(
    .PX_WIDTH(10), .OUT_WIDTH(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1)
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .axi4_video_i(vid),
    .red_o(red), .green_o(green), .blue_o(blue), .de_o(de),
    .h_sync_o(hs), .v_sync_o(vs), .locked_o(locked),
    .underflow_o(uf), .frame_err_o(fe)
  );

  typedef struct {
    logic [29:0] data;
    logic        user, last;
    logic [7:0]  r, g, b;
  } beat_t;

  typedef struct {
    int         h, v;
    logic       de, hs, vs, lk, uf, fe, rdy, act_rdy;
    logic [7:0] r, g, b;
  } exp_t;

  typedef enum {M_WAIT, M_LOCK, M_RESYNC} mst_t;

  beat_t src[$];
  exp_t  sb[$];
  int checks = 0, fails = 0, uf_seen = 0, fe_seen = 0;
  int h = 0, v = 0;
  mst_t ms = M_WAIT;
  bit auto_feed = 0, stall_en = 0, last_en = 0, user_en = 0;

  // Colour bars for h = 0..7 when unlocked (pattern build only).
  logic [7:0] bar_r = 8'b00110011, bar_g = 8'b00001111, bar_b = 8'b01010101;

  task automatic check(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0b, want %0b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_frame();
    beat_t b;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        if (((x + y) % 2) == 0) begin
          b.data = {10'h3FF, 10'h200, 10'h001}; b.r = 8'hFF; b.g = 8'h00; b.b = 8'h80;
        end else begin
          b.data = {10'h155, 10'h0AA, 10'h2F0}; b.r = 8'h55; b.g = 8'hBC; b.b = 8'h2A;
        end
        b.user = (x == 0 && y == 0);
        b.last = (x == 7);
        src.push_back(b);
      end
  endtask

  task automatic push_reset();
    exp_t e;
    vid.tvalid = 1'b0; vid.tuser = 1'b0; vid.tlast = 1'b0; vid.tdata = '0;
    #1;
    e = '{h: -1, v: -1, de: 0, hs: 0, vs: 0, lk: 0, uf: 0, fe: 0, rdy: 1,
          act_rdy: vid.tready, r: 8'h00, g: 8'h00, b: 8'h00};
    sb.push_back(e);
  endtask

  // One raster clock: drive stream, predict the registered response.
  task automatic step();
    exp_t  e;
    beat_t b;
    logic  act, tv, tu, tl, rdy;
    mst_t  ns;
    if (auto_feed && src.size() < 32) push_frame();
    act = (h < 8) && (v < 4);
    b = '{data: '0, user: 0, last: 0, r: 0, g: 0, b: 0};
    if (src.size() > 0) b = src[0];
    tv = (src.size() > 0);
    tu = b.user;
    tl = b.last;
    if (ms == M_LOCK && stall_en && h == 3 && v == 1) begin tv = 0; stall_en = 0; end
    if (ms == M_LOCK && last_en && h == 5 && v == 2) begin tl = 1; last_en = 0; end
    if (ms == M_LOCK && user_en && h == 2 && v == 0) begin tu = 1; user_en = 0; end

    e = '{h: h, v: v, de: act, hs: (h == 10 || h == 11), vs: (v == 5), lk: (ms == M_LOCK),
          uf: 0, fe: 0, rdy: 1, act_rdy: 0, r: 8'h00, g: 8'h00, b: 8'h00};
`ifdef AXI4_HV_TEST_PATTERN_EN
    if (ms != M_LOCK && act) begin
      e.r = {8{bar_r[h]}}; e.g = {8{bar_g[h]}}; e.b = {8{bar_b[h]}};
    end
`endif
    ns = ms;
    case (ms)
      M_WAIT: begin
        rdy = !(tv && tu);
        if (tv && tu && h == 13 && v == 6) ns = M_LOCK;
      end
      M_RESYNC: begin
        rdy = !(tv && tu);
        ns = M_WAIT;
      end
      default: begin
        rdy = act;
        if (act && !tv) begin
          e.uf = 1; ns = M_RESYNC;
        end else if (act) begin
          e.r = b.r; e.g = b.g; e.b = b.b;
          if ((tu && !(h == 0 && v == 0)) || (tl != (h == 7))) begin
            e.fe = 1; ns = M_RESYNC;
          end
        end
      end
    endcase
    e.rdy = rdy;

    vid.tvalid = tv; vid.tdata = b.data; vid.tuser = tu; vid.tlast = tl;
    #1;
    e.act_rdy = vid.tready;
    sb.push_back(e);
    if (tv && rdy && src.size() > 0) void'(src.pop_front());
    if (h == 13) begin h = 0; v = (v == 6) ? 0 : v + 1; end
    else h = h + 1;
    ms = ns;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  // Monitor: compare every clock's registered outputs with the queued prediction.
  exp_t m;
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      uf_seen += int'(uf);
      fe_seen += int'(fe);
      checks++;
      if ({de, hs, vs, locked, uf, fe, red, green, blue, m.act_rdy} !==
          {m.de, m.hs, m.vs, m.lk, m.uf, m.fe, m.r, m.g, m.b, m.rdy}) begin
        fails++;
        $display("FAIL pixel(h=%0d,v=%0d): got de=%0b hs=%0b vs=%0b lk=%0b uf=%0b fe=%0b rgb=%02h/%02h/%02h rdy=%0b, want de=%0b hs=%0b vs=%0b lk=%0b uf=%0b fe=%0b rgb=%02h/%02h/%02h rdy=%0b",
                 m.h, m.v, de, hs, vs, locked, uf, fe, red, green, blue, m.act_rdy,
                 m.de, m.hs, m.vs, m.lk, m.uf, m.fe, m.r, m.g, m.b, m.rdy);
      end
    end
  end

  initial begin
    vid.tvalid = 1'b0; vid.tdata = '0; vid.tuser = 1'b0; vid.tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push_reset();
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Free-running timing with no stream.
    run(97);
    check("no_lock_without_stream", locked, 1'b0);

    // Lock at the frame boundary, then pass-through.
    auto_feed = 1;
    run(98 * 3);
    check("locked_after_sof", locked, 1'b1);

    // Underflow at (3,1).
    stall_en = 1;
    run(98 * 3);
    check_int("underflow_pulses", uf_seen, 1);
    check("relock_after_underflow", locked, 1'b1);

    // Early tlast at (5,2).
    last_en = 1;
    run(98 * 3);
    check_int("frame_err_early_tlast", fe_seen, 1);
    check("relock_after_tlast_err", locked, 1'b1);

    // Stray tuser at (2,0).
    user_en = 1;
    run(98 * 3);
    check_int("frame_err_stray_tuser", fe_seen, 2);
    check("relock_after_tuser_err", locked, 1'b1);

    // Reset mid-frame at (4,2), two clocks low.
    for (int i = 0; i < 200 && !(h == 4 && v == 2); i++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst_n = 1'b0;
    push_reset();
    check("reset_async_de", de, 1'b0);
    check("reset_async_locked", locked, 1'b0);
    @(negedge clk);
    push_reset();
    @(negedge clk);
    rst_n = 1'b1;
    h = 0; v = 0; ms = M_WAIT; src.delete();
    stall_en = 0; last_en = 0; user_en = 0;
    step();
    run(98 * 2);
    check("relock_after_reset", locked, 1'b1);
    check_int("no_extra_underflow", uf_seen, 1);

    @(posedge clk);
    #2;
    check_int("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
